// File: rtl/fp_issue_ctrl_pkg.sv
// rtl/fp_issue_ctrl_pkg.sv - shared types and constants for the FP issue stage
// Purpose: opcode / error-code types reused by the FP units, plus the issue FSM
//          state encoding and the quiet-NaN returned on a unit timeout.
// Ports:   none (package)
package fp_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } opcode_t;

    typedef logic [2:0] o_err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AS_WAIT,
        S_MUL_STRB,
        S_MUL_WAIT,
        S_DIV_START,
        S_DIV_BUSY,
        S_DIV_DONE,
        S_RESP
    } issue_state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// rtl/fp_issue_ctrl_if.sv - request/response handshake bundle for the FP issue stage
// Purpose: groups the upstream request channel and downstream response channel.
// Ports:   none; modport master = requester side, slave = fp_issue_ctrl side.
interface fp_issue_ctrl_if;
    import fp_issue_ctrl_pkg::*;

    logic        req_valid;
    logic        req_ready;
    opcode_t     req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    o_err_t      resp_err;
    logic        resp_timeout;

    modport master (
        output req_valid, req_opcode, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err, resp_timeout
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err, resp_timeout
    );

endinterface

// File: rtl/fp_issue_ctrl_timer.sv
// rtl/fp_issue_ctrl_timer.sv - loadable down-counter with expire flag
// Purpose: shared wait-state timer; load sets the count, which then decrements
//          to zero and holds. expired is high while the count is zero.
// Ports:   clk, reset (sync, active-high), load, load_val[W], expired
module fp_issue_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/fp_issue_ctrl.sv
// rtl/fp_issue_ctrl.sv - single-issue sequencer in front of the FP add/sub, mul and div units
// Purpose: accepts one {opcode,a,b} request, drives the selected unit's handshake,
//          captures its result/error and returns it on the response channel.
// Ports:   clk, reset (sync, active-high), bus (fp_issue_ctrl_if.slave),
//          as_* operand fields / as_fp_out, as_err       (add_sub_top)
//          mul_in_A/B, mul_strb_A/B, mul_A/B_ack, mul_prod,
//          mul_prod_stb, mul_prod_ack                     (fp_multiplier)
//          div_a/b, div_fdiv, div_busy, div_s, div_err    (fdiv_newton)
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int EXP_BITS   = 8,
    parameter int SIG_BITS   = 23,
    parameter int ADDSUB_LAT = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    fp_issue_ctrl_if.slave      bus,
    output logic                as_opcode,
    output logic                as_sign1,
    output logic                as_sign2,
    output logic [EXP_BITS-1:0] as_exp1,
    output logic [EXP_BITS-1:0] as_exp2,
    output logic [SIG_BITS-1:0] as_sig1,
    output logic [SIG_BITS-1:0] as_sig2,
    input  logic [31:0]         as_fp_out,
    input  o_err_t              as_err,
    output logic [31:0]         mul_in_A,
    output logic [31:0]         mul_in_B,
    output logic                mul_strb_A,
    output logic                mul_strb_B,
    input  logic                mul_A_ack,
    input  logic                mul_B_ack,
    input  logic [31:0]         mul_prod,
    input  logic                mul_prod_stb,
    output logic                mul_prod_ack,
    output logic [31:0]         div_a,
    output logic [31:0]         div_b,
    output logic                div_fdiv,
    input  logic                div_busy,
    input  logic [31:0]         div_s,
    input  o_err_t              div_err
);

    localparam int SB   = EXP_BITS + SIG_BITS;
    localparam int TMAX = (TIMEOUT > ADDSUB_LAT) ? TIMEOUT : ADDSUB_LAT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LAT_LOAD = TW'(ADDSUB_LAT - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    issue_state_t  state;
    logic          accept;
    logic          a_done;
    logic          b_done;
    logic          progress;
    logic          tmo_fire;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

    assign accept = bus.req_valid && bus.req_ready;
    // A strobe counts as done if it was already dropped or is being acked now.
    assign a_done = !mul_strb_A || mul_A_ack;
    assign b_done = !mul_strb_B || mul_B_ack;

    // progress = the event that ends the current wait state normally; it also
    // reloads the timer for the next wait state and beats a same-cycle timeout.
    always_comb begin
        progress = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TMO_LOAD;
        tmo_fire = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_load = accept;
                if (bus.req_opcode == OP_ADD || bus.req_opcode == OP_SUB) begin
                    tmr_val = LAT_LOAD;
                end
            end
            S_MUL_STRB:  begin progress = a_done && b_done; tmr_load = progress; end
            S_MUL_WAIT:  progress = mul_prod_stb;
            S_DIV_START: begin progress = !div_busy; tmr_load = progress; end
            S_DIV_BUSY:  begin progress = div_busy;  tmr_load = progress; end
            S_DIV_DONE:  progress = !div_busy;
            default:     ;
        endcase
        if (state == S_MUL_STRB || state == S_MUL_WAIT || state == S_DIV_START ||
            state == S_DIV_BUSY || state == S_DIV_DONE) begin
            tmo_fire = tmr_expired && !progress;
        end
    end

    fp_issue_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_result  <= '0;
            bus.resp_err     <= '0;
            bus.resp_timeout <= 1'b0;
            as_opcode        <= 1'b0;
            as_sign1         <= 1'b0;
            as_sign2         <= 1'b0;
            as_exp1          <= '0;
            as_exp2          <= '0;
            as_sig1          <= '0;
            as_sig2          <= '0;
            mul_in_A         <= '0;
            mul_in_B         <= '0;
            mul_strb_A       <= 1'b0;
            mul_strb_B       <= 1'b0;
            mul_prod_ack     <= 1'b0;
            div_a            <= '0;
            div_b            <= '0;
            div_fdiv         <= 1'b0;
        end else begin
            mul_prod_ack <= 1'b0;
            div_fdiv     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        case (bus.req_opcode)
                            OP_ADD, OP_SUB: begin
                                as_opcode <= (bus.req_opcode == OP_SUB);
                                as_sign1  <= bus.req_a[SB];
                                as_sign2  <= bus.req_b[SB];
                                as_exp1   <= bus.req_a[SB-1:SIG_BITS];
                                as_exp2   <= bus.req_b[SB-1:SIG_BITS];
                                as_sig1   <= bus.req_a[SIG_BITS-1:0];
                                as_sig2   <= bus.req_b[SIG_BITS-1:0];
                                state     <= S_AS_WAIT;
                            end
                            OP_MUL: begin
                                mul_in_A   <= bus.req_a;
                                mul_in_B   <= bus.req_b;
                                mul_strb_A <= 1'b1;
                                mul_strb_B <= 1'b1;
                                state      <= S_MUL_STRB;
                            end
                            default: begin
                                div_a <= bus.req_a;
                                div_b <= bus.req_b;
                                state <= S_DIV_START;
                            end
                        endcase
                    end
                end
                S_AS_WAIT: begin
                    if (tmr_expired) begin
                        bus.resp_result  <= as_fp_out;
                        bus.resp_err     <= as_err;
                        bus.resp_timeout <= 1'b0;
                        bus.resp_valid   <= 1'b1;
                        state            <= S_RESP;
                    end
                end
                S_MUL_STRB: begin
                    if (mul_A_ack) mul_strb_A <= 1'b0;
                    if (mul_B_ack) mul_strb_B <= 1'b0;
                    if (progress) state <= S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    if (mul_prod_stb) begin
                        bus.resp_result  <= mul_prod;
                        bus.resp_err     <= '0;
                        bus.resp_timeout <= 1'b0;
                        bus.resp_valid   <= 1'b1;
                        mul_prod_ack     <= 1'b1;
                        state            <= S_RESP;
                    end
                end
                S_DIV_START: begin
                    if (progress) begin
                        div_fdiv <= 1'b1;
                        state    <= S_DIV_BUSY;
                    end
                end
                S_DIV_BUSY: begin
                    if (progress) state <= S_DIV_DONE;
                end
                S_DIV_DONE: begin
                    if (progress) begin
                        bus.resp_result  <= div_s;
                        bus.resp_err     <= div_err;
                        bus.resp_timeout <= 1'b0;
                        bus.resp_valid   <= 1'b1;
                        state            <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Forced completion overrides whatever the wait state decided above.
            if (tmo_fire) begin
                mul_strb_A       <= 1'b0;
                mul_strb_B       <= 1'b0;
                bus.resp_result  <= QNAN;
                bus.resp_err     <= '0;
                bus.resp_timeout <= 1'b1;
                bus.resp_valid   <= 1'b1;
                state            <= S_RESP;
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb/tb_fp_issue_ctrl.sv - directed self-checking bench for fp_issue_ctrl
module tb_fp_issue_ctrl;
    import fp_issue_ctrl_pkg::*;

    localparam int LAT = 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_issue_ctrl_if bus();

    logic        as_opcode, as_sign1, as_sign2;
    logic [7:0]  as_exp1, as_exp2;
    logic [22:0] as_sig1, as_sig2;
    logic [31:0] as_fp_out;
    logic [2:0]  as_err;
    logic [31:0] mul_in_A, mul_in_B, mul_prod;
    logic        mul_strb_A, mul_strb_B, mul_A_ack, mul_B_ack, mul_prod_stb, mul_prod_ack;
    logic [31:0] div_a, div_b, div_s;
    logic        div_fdiv, div_busy;
    logic [2:0]  div_err;

    fp_issue_ctrl #(.EXP_BITS(8), .SIG_BITS(23), .ADDSUB_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .as_opcode(as_opcode), .as_sign1(as_sign1), .as_sign2(as_sign2),
        .as_exp1(as_exp1), .as_exp2(as_exp2), .as_sig1(as_sig1), .as_sig2(as_sig2),
        .as_fp_out(as_fp_out), .as_err(as_err),
        .mul_in_A(mul_in_A), .mul_in_B(mul_in_B), .mul_strb_A(mul_strb_A), .mul_strb_B(mul_strb_B),
        .mul_A_ack(mul_A_ack), .mul_B_ack(mul_B_ack), .mul_prod(mul_prod),
        .mul_prod_stb(mul_prod_stb), .mul_prod_ack(mul_prod_ack),
        .div_a(div_a), .div_b(div_b), .div_fdiv(div_fdiv), .div_busy(div_busy),
        .div_s(div_s), .div_err(div_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int fdiv_cnt = 0;

    always @(negedge clk) begin
        if (mul_prod_ack) ack_cnt++;
        if (div_fdiv) fdiv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input opcode_t op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        step();
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic release_resp(input string tag);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check({tag, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   base;
        logic stable;

        bus.req_valid = 1'b0; bus.req_opcode = OP_ADD; bus.req_a = '0; bus.req_b = '0;
        bus.resp_ready = 1'b0;
        as_fp_out = '0; as_err = '0;
        mul_A_ack = 1'b0; mul_B_ack = 1'b0; mul_prod = '0; mul_prod_stb = 1'b0;
        div_busy = 1'b0; div_s = '0; div_err = '0;

        step(); step();
        reset = 1'b0;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_result", bus.resp_result, 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_timeout", 32'(bus.resp_timeout), 32'd0);
        check("rst_strobes", {30'd0, mul_strb_A, mul_strb_B}, 32'd0);
        check("rst_fdiv_ack", {30'd0, div_fdiv, mul_prod_ack}, 32'd0);

        // ADD 1.0 + 2.0, then hold the response for 20 cycles
        as_fp_out = 32'h4040_0000; as_err = 3'd0;
        issue(OP_ADD, 32'h3F80_0000, 32'h4000_0000);
        check("add_as_exp1", 32'(as_exp1), 32'h7F);
        check("add_as_exp2", 32'(as_exp2), 32'h80);
        check("add_as_opcode", 32'(as_opcode), 32'd0);
        check("add_req_ready_busy", 32'(bus.req_ready), 32'd0);
        wait_resp(n);
        check("add_latency", 32'(n + 1), 32'(LAT + 1));
        check("add_result", bus.resp_result, 32'h4040_0000);
        check("add_err", 32'(bus.resp_err), 32'd0);
        check("add_timeout", 32'(bus.resp_timeout), 32'd0);
        as_fp_out = 32'hDEAD_BEEF;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.resp_valid || bus.resp_result != 32'h4040_0000 || bus.req_ready) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        release_resp("add");

        // SUB 1.0 - 3.0 with an error code from the unit
        as_fp_out = 32'hC000_0000; as_err = 3'b101;
        issue(OP_SUB, 32'h3F80_0000, 32'h4040_0000);
        check("sub_as_opcode", 32'(as_opcode), 32'd1);
        check("sub_as_sig2", 32'(as_sig2), 32'h40_0000);
        wait_resp(n);
        check("sub_latency", 32'(n + 1), 32'(LAT + 1));
        check("sub_result", bus.resp_result, 32'hC000_0000);
        check("sub_err", 32'(bus.resp_err), 32'd5);
        release_resp("sub");
        as_err = 3'd0;

        // MUL: B acked first, A two cycles later, product 10 cycles after that
        base = ack_cnt;
        issue(OP_MUL, 32'h4000_0000, 32'h4040_0000);
        check("mul_strobes_up", {30'd0, mul_strb_A, mul_strb_B}, 32'd3);
        check("mul_in_A", mul_in_A, 32'h4000_0000);
        check("mul_in_B", mul_in_B, 32'h4040_0000);
        mul_B_ack = 1'b1; step(); mul_B_ack = 1'b0;
        check("mul_b_dropped", {30'd0, mul_strb_A, mul_strb_B}, 32'd2);
        step();
        mul_A_ack = 1'b1; step(); mul_A_ack = 1'b0;
        check("mul_a_dropped", 32'(mul_strb_A), 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("mul_no_early_resp", 32'(bus.resp_valid), 32'd0);
        mul_prod = 32'h40C0_0000; mul_prod_stb = 1'b1;
        step();
        mul_prod_stb = 1'b0;
        check("mul_prod_ack_pulse", 32'(mul_prod_ack), 32'd1);
        wait_resp(n);
        check("mul_result", bus.resp_result, 32'h40C0_0000);
        check("mul_err", 32'(bus.resp_err), 32'd0);
        step(); step(); step();
        check("mul_ack_count", 32'(ack_cnt - base), 32'd1);
        release_resp("mul");

        // DIV issued while the divider is busy
        base = fdiv_cnt;
        div_busy = 1'b1; div_s = 32'h1111_1111;
        issue(OP_DIV, 32'h4120_0000, 32'h4000_0000);
        check("div_a", div_a, 32'h4120_0000);
        for (int i = 0; i < 5; i++) step();
        check("div_stall_no_fdiv", 32'(fdiv_cnt - base), 32'd0);
        div_busy = 1'b0;
        step();
        check("div_fdiv_high", 32'(div_fdiv), 32'd1);
        div_busy = 1'b1;
        step();
        check("div_fdiv_low", 32'(div_fdiv), 32'd0);
        step(); step();
        div_s = 32'h40A0_0000; div_err = 3'b010; div_busy = 1'b0;
        step();
        div_s = 32'h2222_2222; div_err = 3'd0;
        wait_resp(n);
        check("div_result", bus.resp_result, 32'h40A0_0000);
        check("div_err", 32'(bus.resp_err), 32'd2);
        check("div_fdiv_count", 32'(fdiv_cnt - base), 32'd1);
        release_resp("div");

        // DIV where busy never rises -> forced completion
        base = fdiv_cnt;
        issue(OP_DIV, 32'h4120_0000, 32'h0000_0000);
        n = 0;
        while (!div_fdiv && n < 50) begin step(); n++; end
        check("dtmo_fdiv_seen", 32'(div_fdiv), 32'd1);
        wait_resp(n);
        check("dtmo_latency", 32'(n), 32'(TMO));
        check("dtmo_timeout", 32'(bus.resp_timeout), 32'd1);
        check("dtmo_result", bus.resp_result, 32'h7FC0_0000);
        check("dtmo_err", 32'(bus.resp_err), 32'd0);
        check("dtmo_fdiv_count", 32'(fdiv_cnt - base), 32'd1);
        release_resp("dtmo");

        // Reset during MUL_WAIT, then a normal ADD
        issue(OP_MUL, 32'h3F80_0000, 32'h4000_0000);
        mul_A_ack = 1'b1; mul_B_ack = 1'b1; step(); mul_A_ack = 1'b0; mul_B_ack = 1'b0;
        check("rmul_both_dropped", {30'd0, mul_strb_A, mul_strb_B}, 32'd0);
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        check("rmul_req_ready", 32'(bus.req_ready), 32'd1);
        check("rmul_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rmul_resp_result", bus.resp_result, 32'h0);
        check("rmul_resp_timeout", 32'(bus.resp_timeout), 32'd0);
        check("rmul_mul_in_A", mul_in_A, 32'h0);
        mul_prod = 32'h1234_5678; mul_prod_stb = 1'b1;
        step();
        mul_prod_stb = 1'b0;
        check("idle_stray_stb_ack", 32'(mul_prod_ack), 32'd0);
        check("idle_stray_stb_valid", 32'(bus.resp_valid), 32'd0);
        as_fp_out = 32'h4000_0000;
        issue(OP_ADD, 32'h3F80_0000, 32'h3F80_0000);
        wait_resp(n);
        check("radd_latency", 32'(n + 1), 32'(LAT + 1));
        check("radd_result", bus.resp_result, 32'h4000_0000);
        release_resp("radd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
